// File: rtl/fdpacker_pkg.sv
// fdpacker_pkg: shared definitions for the FP64 packer datapath.
//   - rounding-mode encodings (RISC-V frm)
//   - binary64 constants (bias, exponent saturation, canonical NaN, max finite)
//   - fflags bit positions
//   - per-beat metadata carried down the pipe
//   - rounding helpers shared by the round/pack stage
package fdpacker_pkg;

    localparam logic [2:0] RM_RNE = 3'b000;
    localparam logic [2:0] RM_RTZ = 3'b001;
    localparam logic [2:0] RM_RDN = 3'b010;
    localparam logic [2:0] RM_RUP = 3'b011;
    localparam logic [2:0] RM_RMM = 3'b100;

    localparam int FP64_BIAS = 1023;
    localparam int EXP_MAX   = 2047;

    localparam logic [63:0] FP64_CANON_NAN  = 64'h7FF8_0000_0000_0000;
    // Magnitude only; the sign is prepended at pack time.
    localparam logic [62:0] FP64_MAX_FINITE = 63'h7FEF_FFFF_FFFF_FFFF;

    localparam int FLAG_NX = 0;
    localparam int FLAG_UF = 1;
    localparam int FLAG_OF = 2;
    localparam int FLAG_DZ = 3;
    localparam int FLAG_NV = 4;

    typedef enum logic [1:0] {
        CLS_NUM,
        CLS_ZERO,
        CLS_INF,
        CLS_NAN
    } fp_cls_e;

    typedef struct packed {
        logic       sign;
        fp_cls_e    cls;
        logic [2:0] rm;
    } beat_meta_t;

    // Round-up decision for a magnitude given the bits around the cut point.
    function automatic logic rm_increment(input logic [2:0] rm, input logic sign,
                                          input logic lsb, input logic guard,
                                          input logic sticky);
        case (rm)
            RM_RNE:  return guard & (sticky | lsb);
            RM_RTZ:  return 1'b0;
            RM_RDN:  return sign & (guard | sticky);
            RM_RUP:  return !sign & (guard | sticky);
            RM_RMM:  return guard;
            default: return guard & (sticky | lsb);
        endcase
    endfunction

    // On overflow: 1 selects infinity, 0 selects the largest finite value.
    function automatic logic ovf_to_inf(input logic [2:0] rm, input logic sign);
        case (rm)
            RM_RTZ:  return 1'b0;
            RM_RDN:  return sign;
            RM_RUP:  return !sign;
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/fdlzc64.sv
// fdlzc64: combinational 64-bit leading-zero counter.
//   a     in  64  operand
//   count out 7   number of leading zeros, 64 when a is zero
module fdlzc64 (
    input  logic [63:0] a,
    output logic [6:0]  count
);

    // NOTE: always_comb assigns a default before any conditional write, so no latch is inferred.
    always_comb begin
        count = 7'd64;
        // Scan upward so the highest set bit is the last one to win.
        for (int i = 0; i < 64; i++) begin
            if (a[i]) count = 7'(63 - i);
        end
    end

endmodule

// File: rtl/fdpacker.sv
// fdpacker: 3-stage FP64 packer (normalize, denormalize, round/pack).
//   clk, rst            clock, asynchronous active-high reset
//   in_valid/in_ready   input handshake
//   in_sign, in_exp     sign and signed exponent; value = mant * 2^(exp-63)
//   in_mant, in_sticky  integer mantissa and below-LSB sticky
//   in_is_nan/in_is_inf special-class overrides
//   in_rm               rounding mode (101..111 behave as RNE)
//   out_valid/out_ready output handshake
//   out_result          packed binary64
//   out_fflags          {NV,DZ,OF,UF,NX}
module fdpacker
    import fdpacker_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_sign,
    input  logic [12:0] in_exp,
    input  logic [63:0] in_mant,
    input  logic        in_sticky,
    input  logic        in_is_nan,
    input  logic        in_is_inf,
    input  logic [2:0]  in_rm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_result,
    output logic [4:0]  out_fflags
);

    // ---------------- flow control ----------------
    logic s1_valid, s2_valid, s3_valid;
    logic s1_load, s2_load, s3_load;

    assign s3_load   = !s3_valid || out_ready;
    assign s2_load   = !s2_valid || s3_load;
    assign s1_load   = !s1_valid || s2_load;
    assign in_ready  = s1_load;
    assign out_valid = s3_valid;

    // ---------------- S1: classify + normalize ----------------
    logic [6:0]         lz;
    beat_meta_t         meta_in;
    logic signed [13:0] be_in;

    fdlzc64 u_lzc (
        .a     (in_mant),
        .count (lz)
    );

    always_comb begin
        meta_in.sign = in_sign;
        meta_in.rm   = in_rm;
        if (in_is_nan)                          meta_in.cls = CLS_NAN;
        else if (in_is_inf)                     meta_in.cls = CLS_INF;
        else if (in_mant == '0 && !in_sticky)   meta_in.cls = CLS_ZERO;
        else                                    meta_in.cls = CLS_NUM;
        // A zero mantissa with sticky set is a sub-min-subnormal residue: pin it
        // into the subnormal range so the shifter folds it entirely into sticky.
        if (in_mant == '0) be_in = '0;
        else be_in = $signed({in_exp[12], in_exp}) - $signed({7'b0, lz})
                   + $signed(14'(FP64_BIAS));
    end

    beat_meta_t         s1_meta;
    logic [63:0]        s1_m;
    logic signed [13:0] s1_be;
    logic               s1_sticky;

    // ---------------- S2: denormalize ----------------
    logic signed [13:0] shamt;
    logic [6:0]         sh;
    logic [63:0]        lost_mask;
    logic [62:0]        m_dn;
    logic [10:0]        exp_dn;
    logic               sticky_dn, tiny_dn, ovf_dn;

    always_comb begin
        shamt     = 14'sd1 - s1_be;
        sh        = '0;
        lost_mask = '0;
        m_dn      = s1_m[62:0];
        exp_dn    = s1_be[10:0];
        sticky_dn = s1_sticky;
        tiny_dn   = 1'b0;
        ovf_dn    = s1_be >= $signed(14'(EXP_MAX));
        if (s1_be <= 14'sd0) begin
            tiny_dn = 1'b1;
            exp_dn  = '0;
            sh      = (shamt > 14'sd65) ? 7'd65 : shamt[6:0];
            if (sh >= 7'd64) begin
                m_dn      = '0;
                lost_mask = '1;
            end else begin
                m_dn      = 63'(s1_m >> sh);
                lost_mask = (64'd1 << sh) - 64'd1;
            end
            sticky_dn = s1_sticky | (|(s1_m & lost_mask));
        end
    end

    beat_meta_t  s2_meta;
    logic [62:0] s2_m;
    logic [10:0] s2_exp;
    logic        s2_sticky, s2_tiny, s2_ovf;

    // ---------------- S3: round + pack ----------------
    logic [51:0] frac;
    logic        guard, sticky_r, inc, nx;
    logic [62:0] sum;
    logic [63:0] res_c;
    logic [4:0]  flags_c;

    always_comb begin
        frac     = s2_m[62:11];
        guard    = s2_m[10];
        sticky_r = (|s2_m[9:0]) | s2_sticky;
        nx       = guard | sticky_r;
        inc      = rm_increment(s2_meta.rm, s2_meta.sign, frac[0], guard, sticky_r);
        // Carry out of the fraction bumps the exponent field for free.
        sum      = {s2_exp, frac} + {62'd0, inc};
        flags_c  = '0;
        flags_c[FLAG_NV] = 1'b0;
        flags_c[FLAG_DZ] = 1'b0;
        case (s2_meta.cls)
            CLS_NAN:  res_c = FP64_CANON_NAN;
            CLS_INF:  res_c = {s2_meta.sign, 11'h7FF, 52'd0};
            CLS_ZERO: res_c = {s2_meta.sign, 63'd0};
            default: begin
                if (s2_ovf || sum[62:52] == 11'(EXP_MAX)) begin
                    res_c = ovf_to_inf(s2_meta.rm, s2_meta.sign)
                          ? {s2_meta.sign, 11'h7FF, 52'd0}
                          : {s2_meta.sign, FP64_MAX_FINITE};
                    flags_c[FLAG_OF] = 1'b1;
                    flags_c[FLAG_NX] = 1'b1;
                end else begin
                    res_c = {s2_meta.sign, sum};
                    flags_c[FLAG_UF] = s2_tiny & nx;
                    flags_c[FLAG_NX] = nx;
                end
            end
        endcase
    end

    // ---------------- registers ----------------
    // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid   <= 1'b0;
            s2_valid   <= 1'b0;
            s3_valid   <= 1'b0;
            out_result <= '0;
            out_fflags <= '0;
        end else begin
            if (s1_load) s1_valid <= in_valid;
            if (s2_load) s2_valid <= s1_valid;
            if (s3_load) begin
                s3_valid <= s2_valid;
                if (s2_valid) begin
                    out_result <= res_c;
                    out_fflags <= flags_c;
                end
            end
        end
    end

    // NOTE: payload registers are qualified by their valid bits, so they need no reset.
    always_ff @(posedge clk) begin
        if (s1_load && in_valid) begin
            s1_meta   <= meta_in;
            s1_m      <= in_mant << lz;
            s1_be     <= be_in;
            s1_sticky <= in_sticky;
        end
        if (s2_load && s1_valid) begin
            s2_meta   <= s1_meta;
            s2_m      <= m_dn;
            s2_exp    <= exp_dn;
            s2_sticky <= sticky_dn;
            s2_tiny   <= tiny_dn;
            s2_ovf    <= ovf_dn;
        end
    end

endmodule

// File: tb/tb_fdpacker.sv
// tb_fdpacker: scoreboard bench for fdpacker. Expected results are pushed when
// a beat is accepted and popped when the packer presents a result.
module tb_fdpacker;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, in_sign, in_sticky, in_is_nan, in_is_inf;
    logic [12:0] in_exp;
    logic [63:0] in_mant;
    logic [2:0]  in_rm;
    logic        out_valid, out_ready;
    logic [63:0] out_result;
    logic [4:0]  out_fflags;

    fdpacker dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sign    (in_sign),
        .in_exp     (in_exp),
        .in_mant    (in_mant),
        .in_sticky  (in_sticky),
        .in_is_nan  (in_is_nan),
        .in_is_inf  (in_is_inf),
        .in_rm      (in_rm),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_fflags (out_fflags)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        sign;
        logic [12:0] ex;
        logic [63:0] mant;
        logic        sticky;
        logic        nan;
        logic        inf;
        logic [2:0]  rm;
    } beat_t;

    logic [68:0] sb_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    int          acc_cyc = 0;
    int          out_cyc = 0;
    int          n_out = 0;
    bit          accepted = 0;
    bit          rand_ready = 0;
    bit          kmode = 0;
    logic [68:0] kval = '0;
    bit          prev_stall = 0;
    logic [63:0] prev_res = '0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic logic [68:0] ovf_val(input logic s, input logic [2:0] rm);
        logic to_inf;
        case (rm)
            3'b001:  to_inf = 1'b0;
            3'b010:  to_inf = s;
            3'b011:  to_inf = !s;
            default: to_inf = 1'b1;
        endcase
        return {5'b00101, s, to_inf ? 63'h7FF0_0000_0000_0000 : 63'h7FEF_FFFF_FFFF_FFFF};
    endfunction

    // Reference: keep the top k significant bits of the value (53 for normals,
    // fewer in the subnormal range), round that integer, then rebuild the field.
    function automatic logic [68:0] ref_pack(input beat_t b);
        int          p, be, k, sh, be_eff;
        logic [63:0] q, field;
        logic        g, r, inc, nx, tiny;
        if (b.nan) return {5'd0, 64'h7FF8_0000_0000_0000};
        if (b.inf) return {5'd0, b.sign, 11'h7FF, 52'd0};
        if (b.mant == '0 && !b.sticky) return {5'd0, b.sign, 63'd0};
        if (b.mant == '0) begin
            q = '0; g = 1'b0; r = 1'b1; tiny = 1'b1; be = 0;
        end else begin
            p = 63;
            while (!b.mant[p]) p--;
            be = int'($signed(b.ex)) - 63 + p + 1023;
            if (be >= 2047) return ovf_val(b.sign, b.rm);
            tiny = (be < 1);
            k  = tiny ? 52 + be : 53;
            sh = p + 1 - k;
            if (sh <= 0) begin
                q = b.mant << (-sh); g = 1'b0; r = b.sticky;
            end else begin
                q = (sh >= 64) ? 64'd0 : b.mant >> sh;
                g = (sh <= 64) ? b.mant[sh-1] : 1'b0;
                r = b.sticky | ((sh - 1 >= 64) ? 1'b1
                                : ((b.mant & ((64'd1 << (sh - 1)) - 64'd1)) != 0));
            end
        end
        case (b.rm)
            3'b001:  inc = 1'b0;
            3'b010:  inc = b.sign & (g | r);
            3'b011:  inc = !b.sign & (g | r);
            3'b100:  inc = g;
            default: inc = g & (r | q[0]);
        endcase
        q      = q + 64'(inc);
        be_eff = (be < 1) ? 1 : be;
        field  = (64'(be_eff - 1) << 52) + q;
        nx     = g | r;
        if (field[62:52] == 11'h7FF) return ovf_val(b.sign, b.rm);
        return {3'b000, tiny & nx, nx, b.sign, field[62:0]};
    endfunction

    function automatic beat_t mk(input logic s, input logic [12:0] ex, input logic [63:0] m,
                                 input logic st, input logic nan, input logic inf,
                                 input logic [2:0] rm);
        return {s, ex, m, st, nan, inf, rm};
    endfunction

    function automatic beat_t rand_beat();
        beat_t b;
        int    c;
        b.sign   = 1'($urandom);
        b.rm     = 3'($urandom_range(0, 7));
        b.sticky = ($urandom_range(0, 3) == 0);
        b.mant   = {$urandom, $urandom} >> $urandom_range(0, 63);
        b.ex     = 13'(int'($urandom_range(0, 2400)) - 1200);
        c        = int'($urandom_range(0, 15));
        b.nan    = (c == 0);
        b.inf    = (c == 1);
        if (c == 2) b.mant = '0;
        return b;
    endfunction

    task automatic drive(input beat_t b);
        in_sign = b.sign; in_exp = b.ex; in_mant = b.mant; in_sticky = b.sticky;
        in_is_nan = b.nan; in_is_inf = b.inf; in_rm = b.rm;
    endtask

    // One clock cycle: settle, observe both handshakes, then advance to the next negedge.
    task automatic tick();
        logic [68:0] e;
        if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
        #1;
        accepted = 0;
        if (prev_stall) begin
            check("hold_valid", 64'(out_valid), 64'd1);
            check("hold_result", out_result, prev_res);
        end
        if (in_valid && in_ready) begin
            sb_q.push_back(kmode ? kval
                : ref_pack(mk(in_sign, in_exp, in_mant, in_sticky, in_is_nan, in_is_inf, in_rm)));
            accepted = 1;
            acc_cyc  = cyc;
        end
        if (out_valid && out_ready) begin
            n_out++;
            out_cyc = cyc;
            if (sb_q.size() == 0) begin
                check("spurious_out", 64'(out_valid), 64'd0);
            end else begin
                e = sb_q.pop_front();
                check("result", out_result, e[63:0]);
                check("fflags", 64'(out_fflags), 64'(e[68:64]));
            end
        end
        prev_stall = out_valid && !out_ready;
        prev_res   = out_result;
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic send(input beat_t b, input bit use_k, input logic [68:0] k);
        drive(b);
        in_valid = 1'b1;
        kmode    = use_k;
        kval     = k;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (accepted) break;
        end
        if (!accepted) check("accept_timeout", 64'(accepted), 64'd1);
        in_valid = 1'b0;
        kmode    = 0;
    endtask

    task automatic drain();
        in_valid = 1'b0;
        for (int i = 0; i < 200 && sb_q.size() > 0; i++) tick();
        check("drain_left", 64'(sb_q.size()), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    beat_t bp_beats[5];
    int    idx;
    int    n_before;
    beat_t b_all1;
    beat_t b_ovf;

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        drive(mk(0, 13'd0, 64'd0, 0, 0, 0, 3'd0));
        repeat (3) @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_result", out_result, 64'd0);
        check("rst_out_fflags", 64'(out_fflags), 64'd0);
        rst = 1'b0;
        #1;
        check("rst_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);

        // Latency on an exact normal.
        send(mk(0, 13'd63, 64'd1, 0, 0, 0, 3'd0), 1, {5'd0, 64'h3FF0_0000_0000_0000});
        drain();
        check("latency", 64'(out_cyc - acc_cyc), 64'd3);

        // Known answers, streamed back to back.
        b_all1 = mk(0, 13'd0, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 0, 3'd0);
        b_ovf  = mk(0, 13'd1087, 64'd1, 0, 0, 0, 3'd0);
        send(b_all1, 1, {5'b00001, 64'h4000_0000_0000_0000});
        b_all1.rm = 3'd1;
        send(b_all1, 1, {5'b00001, 64'h3FFF_FFFF_FFFF_FFFF});
        b_all1.rm = 3'd7;
        send(b_all1, 1, {5'b00001, 64'h4000_0000_0000_0000});
        send(b_ovf, 1, {5'b00101, 64'h7FF0_0000_0000_0000});
        b_ovf.rm = 3'd1;
        send(b_ovf, 1, {5'b00101, 64'h7FEF_FFFF_FFFF_FFFF});
        b_ovf.rm = 3'd2;
        send(b_ovf, 1, {5'b00101, 64'h7FEF_FFFF_FFFF_FFFF});
        b_ovf.rm = 3'd3; b_ovf.sign = 1'b1;
        send(b_ovf, 1, {5'b00101, 64'hFFEF_FFFF_FFFF_FFFF});
        send(mk(0, 13'(-1011), 64'd1, 0, 0, 0, 3'd0), 1, {5'd0, 64'h0000_0000_0000_0001});
        send(mk(0, 13'(-1012), 64'd3, 0, 0, 0, 3'd0), 1, {5'b00011, 64'h0000_0000_0000_0002});
        send(mk(0, 13'(-1023), 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 0, 3'd0), 1,
             {5'b00011, 64'h0010_0000_0000_0000});
        send(mk(1, 13'd0, 64'd0, 1, 0, 0, 3'd2), 1, {5'b00011, 64'h8000_0000_0000_0001});
        send(mk(0, 13'd500, 64'd0, 1, 0, 0, 3'd0), 1, {5'b00011, 64'h0000_0000_0000_0000});
        send(mk(0, 13'd5, 64'd7, 0, 1, 1, 3'd0), 1, {5'd0, 64'h7FF8_0000_0000_0000});
        send(mk(1, 13'd5, 64'd7, 0, 0, 1, 3'd0), 1, {5'd0, 64'hFFF0_0000_0000_0000});
        send(mk(1, 13'd5, 64'd0, 0, 0, 0, 3'd0), 1, {5'd0, 64'h8000_0000_0000_0000});
        drain();

        // Backpressure: five beats offered while the consumer stalls.
        for (int i = 0; i < 5; i++) bp_beats[i] = rand_beat();
        out_ready = 1'b0;
        idx = 0;
        for (int c = 0; c < 6; c++) begin
            if (idx < 5) begin
                drive(bp_beats[idx]);
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            tick();
            if (accepted) idx++;
        end
        check("bp_accepted", 64'(idx), 64'd3);
        check("bp_in_ready", 64'(in_ready), 64'd0);
        out_ready = 1'b1;
        for (int i = idx; i < 5; i++) send(bp_beats[i], 0, '0);
        drain();

        // Random traffic with random consumer stalls.
        rand_ready = 1;
        for (int i = 0; i < 80; i++) send(rand_beat(), 0, '0);
        rand_ready = 0;
        out_ready  = 1'b1;
        drain();

        // Reset with two beats in flight.
        out_ready = 1'b0;
        send(mk(0, 13'd63, 64'd1, 0, 0, 0, 3'd0), 0, '0);
        send(mk(1, 13'd63, 64'd1, 0, 0, 0, 3'd0), 0, '0);
        tick();
        check("inflight_valid", 64'(out_valid), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_valid", 64'(out_valid), 64'd0);
        check("async_rst_result", out_result, 64'd0);
        check("async_rst_fflags", 64'(out_fflags), 64'd0);
        sb_q.delete();
        prev_stall = 0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        out_ready = 1'b1;
        n_before  = n_out;
        repeat (8) tick();
        check("post_rst_outputs", 64'(n_out - n_before), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
